// File: rtl/mem_arbiter_2to1.sv
// Two-requester (I-cache / D-cache) arbiter for a four-banked main memory:
// round-robin ownership, bank-busy/stall gating, burst lock and tagged read returns.
module mem_arbiter_2to1 #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int BANK_LSB = 1,
    parameter int RD_LAT   = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_wr,
    input  logic          i_lock,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          i_rvalid,
    output logic          d_rvalid,
    output logic          i_err,
    output logic          d_err,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [3:0]    mem_busy,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_err
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_I,
        OWN_D
    } state_t;

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;   // 0 = I, 1 = D
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RD_LAT-1:0] rv_q, rv_d;
    logic [RD_LAT-1:0] rid_q, rid_d;               // 0 = I, 1 = D
    logic            i_err_q, i_err_d;
    logic            d_err_q, d_err_d;

    logic [1:0]      i_bank, d_bank;
    logic            i_ok, d_ok;
    logic            gnt_i, gnt_d;
    logic            own_req, own_lock, own_gnt;

    assign i_bank = i_addr[BANK_LSB +: 2];
    assign d_bank = d_addr[BANK_LSB +: 2];
    assign i_ok   = ~mem_busy[i_bank] & ~mem_stall;
    assign d_ok   = ~mem_busy[d_bank] & ~mem_stall;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        own_req      = 1'b0;
        own_lock     = 1'b0;
        own_gnt      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_req && d_req) begin
                    state_d = last_owner_q ? OWN_I : OWN_D;
                end else if (i_req) begin
                    state_d = OWN_I;
                end else if (d_req) begin
                    state_d = OWN_D;
                end
            end
            OWN_I: begin
                gnt_i     = i_req & i_ok;
                own_req   = i_req;
                own_lock  = i_lock;
                own_gnt   = gnt_i;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
            end
            OWN_D: begin
                gnt_d     = d_req & d_ok;
                own_req   = d_req;
                own_lock  = d_lock;
                own_gnt   = gnt_d;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (own_gnt) begin
            last_owner_d = (state_q == OWN_D);
            cnt_d        = cnt_q + CW'(1);
        end
        // Release on an unlocked or final locked beat, or when the owner withdraws.
        if ((state_q == OWN_I || state_q == OWN_D) &&
            ((own_gnt && (!own_lock || cnt_q == LAST_BEAT)) || (!own_req && !own_lock))) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign i_gnt  = gnt_i;
    assign d_gnt  = gnt_d;
    assign mem_rd = (gnt_i & ~i_wr) | (gnt_d & ~d_wr);
    assign mem_wr = (gnt_i & i_wr) | (gnt_d & d_wr);

    always_comb begin
        rv_d     = '0;
        rid_d    = '0;
        rv_d[0]  = mem_rd;
        rid_d[0] = gnt_d;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            rv_d[k]  = rv_q[k-1];
            rid_d[k] = rid_q[k-1];
        end
        i_err_d = mem_err & gnt_i;
        d_err_d = mem_err & gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
            cnt_q        <= '0;
            rv_q         <= '0;
            rid_q        <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            rv_q         <= rv_d;
            rid_q        <= rid_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
        end
    end

    assign i_rvalid = rv_q[RD_LAT-1] & ~rid_q[RD_LAT-1];
    assign d_rvalid = rv_q[RD_LAT-1] &  rid_q[RD_LAT-1];
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;
    assign rdata    = rst ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed vector bench for mem_arbiter_2to1: per-cycle stimulus with hand-computed
// grants, strobes, address mux, read-return and error pulses.
module tb_mem_arbiter_2to1;

    localparam int RD_LAT = 2;
    localparam logic [1:0] ON = 2'd0, OI = 2'd1, OD = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 0, i_wr = 0, i_lock = 0;
    logic [15:0] i_addr = '0, i_wdata = 16'hA5A5;
    logic        d_req = 0, d_wr = 0, d_lock = 0;
    logic [15:0] d_addr = '0, d_wdata = 16'h5A5A;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [3:0]  mem_busy = '0;
    logic        mem_stall = 0;
    logic [15:0] mem_rdata = 16'hBEEF;
    logic        mem_err = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(.AW(16), .DW(16), .BANK_LSB(1), .RD_LAT(RD_LAT), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_lock(i_lock), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_req(d_req), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
        .i_err(i_err), .d_err(d_err), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    // ctrl bits: i_gnt d_gnt mem_rd mem_wr i_rvalid d_rvalid i_err d_err
    typedef struct {
        logic        rst;
        logic        ir, iw, il;
        logic [15:0] ia;
        logic        dr, dw, dl;
        logic [15:0] da;
        logic [3:0]  busy;
        logic        stall, err;
        logic [1:0]  own;
        logic [7:0]  ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ir, input logic iw, input logic il,
                       input logic [15:0] ia, input logic dr, input logic dw, input logic dl,
                       input logic [15:0] da, input logic [3:0] busy, input logic stall,
                       input logic err, input logic [1:0] own, input logic [7:0] ctrl);
        vec_t v;
        v.rst = r; v.ir = ir; v.iw = iw; v.il = il; v.ia = ia;
        v.dr = dr; v.dw = dw; v.dl = dl; v.da = da;
        v.busy = busy; v.stall = stall; v.err = err; v.own = own; v.ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [15:0] exp_addr, exp_wdata;
        int got, lat;

        // 1: lone I read
        add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, OI, 8'b1010_0000);
        add(0, 0,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_1000);
        // 2: tie after reset, then alternation
        add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, OD, 8'b0110_0000);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, OI, 8'b1010_0100);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0020, 1,0,0,16'h0030, 4'b0000,0,0, OD, 8'b0110_1000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0100);
        // 3: locked D burst, forced release after 4 beats, re-entry, withdrawal
        add(0, 0,0,0,16'h0000, 1,0,1,16'h0010, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0010, 4'b0000,0,0, OD, 8'b0110_0000);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0012, 4'b0000,0,0, OD, 8'b0110_0000);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0014, 4'b0000,0,0, OD, 8'b0110_0100);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0016, 4'b0000,0,0, OD, 8'b0110_0100);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0018, 4'b0000,0,0, ON, 8'b0000_0100);
        add(0, 1,0,0,16'h0040, 1,0,1,16'h0018, 4'b0000,0,0, OI, 8'b1010_0100);
        add(0, 0,0,0,16'h0040, 1,0,1,16'h0018, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0040, 1,0,1,16'h0018, 4'b0000,0,0, OD, 8'b0110_1000);
        add(0, 0,0,0,16'h0040, 0,0,0,16'h0018, 4'b0000,0,0, OD, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0100);
        // 4: bank-busy gating of an I write to bank 1
        add(0, 1,1,0,16'h0002, 0,0,0,16'h0000, 4'b0010,0,0, ON, 8'b0000_0000);
        add(0, 1,1,0,16'h0002, 0,0,0,16'h0000, 4'b0010,0,0, OI, 8'b0000_0000);
        add(0, 1,1,0,16'h0002, 0,0,0,16'h0000, 4'b0010,0,0, OI, 8'b0000_0000);
        add(0, 1,1,0,16'h0002, 0,0,0,16'h0000, 4'b0000,0,0, OI, 8'b1001_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        // 5: stall during OWN_D, error on granted beat, error without grant ignored
        add(0, 0,0,0,16'h0000, 1,0,0,16'h0022, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 1,0,0,16'h0022, 4'b0000,1,0, OD, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 1,0,0,16'h0022, 4'b0000,1,0, OD, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 1,0,0,16'h0022, 4'b0000,1,0, OD, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 1,0,0,16'h0022, 4'b0000,0,1, OD, 8'b0110_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0001);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,1, ON, 8'b0000_0100);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        // 6: reset right after a granted read drops the return; D wins next tie
        add(0, 1,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0004, 0,0,0,16'h0000, 4'b0000,0,0, OI, 8'b1010_0000);
        add(1, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0050, 1,0,0,16'h0060, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 1,0,0,16'h0050, 1,0,0,16'h0060, 4'b0000,0,0, OD, 8'b0110_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0000);
        add(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 4'b0000,0,0, ON, 8'b0000_0100);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            @(posedge clk); #1;
            rst = v.rst;
            i_req = v.ir; i_wr = v.iw; i_lock = v.il; i_addr = v.ia;
            d_req = v.dr; d_wr = v.dw; d_lock = v.dl; d_addr = v.da;
            mem_busy = v.busy; mem_stall = v.stall; mem_err = v.err;
            #5;
            exp_addr  = (v.own == OI) ? v.ia : (v.own == OD) ? v.da : 16'h0000;
            exp_wdata = (v.own == OI) ? 16'hA5A5 : (v.own == OD) ? 16'h5A5A : 16'h0000;
            chk("ctrl", n, {24'd0, i_gnt, d_gnt, mem_rd, mem_wr, i_rvalid, d_rvalid, i_err, d_err},
                {24'd0, v.ctrl});
            chk("mem_addr", n, {16'd0, mem_addr}, {16'd0, exp_addr});
            chk("mem_wdata", n, {16'd0, mem_wdata}, {16'd0, exp_wdata});
            chk("rdata", n, {16'd0, rdata}, v.rst ? 32'h0 : 32'h0000BEEF);
        end

        // Hand sequence: measured grant-to-rvalid latency and single-cycle return pulse.
        @(posedge clk); #1;
        rst = 0; d_req = 0; mem_busy = '0; mem_stall = 0; mem_err = 0;
        i_req = 1; i_wr = 0; i_lock = 0; i_addr = 16'h0004;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            #5;
            if (i_gnt === 1'b1) begin got = 1; break; end
            @(posedge clk); #1;
        end
        chk("gnt_wait", 0, got, 1);
        @(posedge clk); #1;
        i_req = 0;
        got = 0; lat = 1;
        for (int c = 0; c < 10; c++) begin
            #5;
            if (i_rvalid === 1'b1) begin got = 1; break; end
            @(posedge clk); #1;
            lat++;
        end
        chk("rvalid_seen", 0, got, 1);
        chk("rd_latency", 0, lat, RD_LAT);
        chk("rdata_ret", 0, {16'd0, rdata}, 32'h0000BEEF);
        @(posedge clk); #6;
        chk("rvalid_pulse", 0, {31'd0, i_rvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
